// File: rtl/freq_meter_mc.sv
`timescale 1ns/1ps
// freq_meter_mc: dual-mode frequency meter for a sampled ADC waveform.
// A hysteresis slicer turns ADC samples into a logic level. Rising edges of that
// level are either counted over a selectable gate (gate mode) or timed over
// N_PER signal periods (period mode). Each result is held, and a stretched valid
// strobe signals it.
// Ports:
//   clk_10m, rst_n            system clock, synchronous active-low reset
//   adc_data                  unsigned ADC sample
//   thr_high, thr_low         hysteresis thresholds
//   enable, mode, gate_sel    run control and measurement configuration
//   clk_adc                   ADC clock (copy of clk_10m)
//   frequency, period_cycles  gate-mode and period-mode results
//   freq_valid                result strobe, stretched VALID_WIDTH cycles
//   overflow, timeout, busy   status of the last result / FSM activity
module freq_meter_mc #(
  parameter int unsigned ADC_W       = 10,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned CLK_HZ      = 10000000,
  parameter int unsigned N_PER       = 16,
  parameter int unsigned TIMEOUT_CYC = 20000000,
  parameter int unsigned VALID_WIDTH = 20000
) (
  input  logic             clk_10m,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] adc_data,
  input  logic [ADC_W-1:0] thr_high,
  input  logic [ADC_W-1:0] thr_low,
  input  logic             enable,
  input  logic             mode,
  input  logic [1:0]       gate_sel,
  output logic             clk_adc,
  output logic [CNT_W-1:0] frequency,
  output logic [CNT_W-1:0] period_cycles,
  output logic             freq_valid,
  output logic             overflow,
  output logic             timeout,
  output logic             busy
);

  localparam int unsigned GATE_W = $clog2(CLK_HZ + 1);
  localparam int unsigned PER_W  = $clog2(N_PER + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned SW     = $clog2(VALID_WIDTH + 2);
  localparam int unsigned PW     = CNT_W + 10;

  localparam logic [GATE_W-1:0] G0_LAST  = GATE_W'(CLK_HZ - 1);
  localparam logic [GATE_W-1:0] G1_LAST  = GATE_W'(CLK_HZ / 10 - 1);
  localparam logic [GATE_W-1:0] G2_LAST  = GATE_W'(CLK_HZ / 100 - 1);
  localparam logic [GATE_W-1:0] G3_LAST  = GATE_W'(CLK_HZ / 1000 - 1);
  localparam logic [PER_W-1:0]  PER_LAST = PER_W'(N_PER - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_DONE} state_t;

  state_t              r_state;
  logic [ADC_W-1:0]    r_adc_d1;
  logic                r_level;
  logic                r_level_d1;
  logic                r_mode;
  logic [1:0]          r_gsel;
  logic [GATE_W-1:0]   r_gate_cnt;
  logic [CNT_W-1:0]    r_edge_cnt;
  logic [CNT_W-1:0]    r_cyc_cnt;
  logic [PER_W-1:0]    r_per_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic [SW-1:0]       r_stretch_cnt;
  logic [CNT_W-1:0]    r_frequency;
  logic [CNT_W-1:0]    r_period;
  logic                r_freq_valid;
  logic                r_overflow;
  logic                r_timeout;
  logic                r_busy;

  logic                w_edge;
  logic [CNT_W-1:0]    w_edge_cnt_nx;
  logic [CNT_W:0]      w_scaled;
  logic [GATE_W-1:0]   w_gate_last;
  logic                w_to_hit;
  logic                w_cyc_full;

  // Multiply the edge count by 1/10/100/1000 using shifts; MSB flags saturation.
  function automatic logic [CNT_W:0] scale_sat(input logic [CNT_W-1:0] c, input logic [1:0] sel);
    logic [PW-1:0] x;
    logic [PW-1:0] p;
    x = PW'(c);
    case (sel)
      2'd0:    p = x;
      2'd1:    p = (x << 3) + (x << 1);
      2'd2:    p = (x << 6) + (x << 5) + (x << 2);
      default: p = (x << 9) + (x << 8) + (x << 7) + (x << 6) + (x << 5) + (x << 3);
    endcase
    if (|p[PW-1:CNT_W]) scale_sat = {1'b1, {CNT_W{1'b1}}};
    else                scale_sat = {1'b0, p[CNT_W-1:0]};
  endfunction

  assign clk_adc       = clk_10m;
  assign frequency     = r_frequency;
  assign period_cycles = r_period;
  assign freq_valid    = r_freq_valid;
  assign overflow      = r_overflow;
  assign timeout       = r_timeout;
  assign busy          = r_busy;

  assign w_edge        = r_level & ~r_level_d1;
  assign w_edge_cnt_nx = (&r_edge_cnt) ? r_edge_cnt : r_edge_cnt + CNT_W'(w_edge);
  assign w_scaled      = scale_sat(w_edge_cnt_nx, r_gsel);
  assign w_to_hit      = (r_to_cnt == TO_LAST);
  assign w_cyc_full    = &r_cyc_cnt;

  // Last cycle index of the latched gate length.
  always_comb begin
    w_gate_last = G3_LAST;
    case (r_gsel)
      2'd0:    w_gate_last = G0_LAST;
      2'd1:    w_gate_last = G1_LAST;
      2'd2:    w_gate_last = G2_LAST;
      default: w_gate_last = G3_LAST;
    endcase
  end

  // Hysteresis slicer; the high threshold wins when both thresholds match.
  always_ff @(posedge clk_10m) begin
    if (!rst_n) begin
      r_adc_d1   <= {1'b1, {(ADC_W-1){1'b0}}};
      r_level    <= 1'b0;
      r_level_d1 <= 1'b0;
    end else begin
      r_adc_d1   <= adc_data;
      if (r_adc_d1 >= thr_high)     r_level <= 1'b1;
      else if (r_adc_d1 <= thr_low) r_level <= 1'b0;
      r_level_d1 <= r_level;
    end
  end

  // Measurement FSM, result registers and valid stretcher.
  always_ff @(posedge clk_10m) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_mode        <= 1'b0;
      r_gsel        <= 2'd0;
      r_gate_cnt    <= '0;
      r_edge_cnt    <= '0;
      r_cyc_cnt     <= '0;
      r_per_cnt     <= '0;
      r_to_cnt      <= '0;
      r_stretch_cnt <= '0;
      r_frequency   <= '0;
      r_period      <= '0;
      r_freq_valid  <= 1'b0;
      r_overflow    <= 1'b0;
      r_timeout     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_mode   <= mode;
            r_gsel   <= gate_sel;
            r_to_cnt <= '0;
            r_state  <= S_ARM;
            r_busy   <= 1'b1;
          end
        end
        S_ARM: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (!r_mode) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_state    <= S_MEASURE;
          end else if (w_to_hit) begin
            r_period      <= '0;
            r_timeout     <= 1'b1;
            r_overflow    <= 1'b0;
            r_state       <= S_DONE;
            r_freq_valid  <= (VALID_WIDTH != 0);
            r_stretch_cnt <= SW'(VALID_WIDTH);
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            // The arming edge starts the period span.
            if (w_edge) begin
              r_cyc_cnt <= '0;
              r_per_cnt <= '0;
              r_state   <= S_MEASURE;
            end
          end
        end
        S_MEASURE: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (!r_mode) begin
            r_edge_cnt <= w_edge_cnt_nx;
            // Final gate cycle: its edge is already folded into w_edge_cnt_nx.
            if (r_gate_cnt == w_gate_last) begin
              r_frequency   <= w_scaled[CNT_W-1:0];
              r_overflow    <= w_scaled[CNT_W];
              r_timeout     <= 1'b0;
              r_state       <= S_DONE;
              r_freq_valid  <= (VALID_WIDTH != 0);
              r_stretch_cnt <= SW'(VALID_WIDTH);
            end else begin
              r_gate_cnt <= r_gate_cnt + GATE_W'(1);
            end
          end else if (w_to_hit) begin
            r_period      <= '0;
            r_timeout     <= 1'b1;
            r_overflow    <= 1'b0;
            r_state       <= S_DONE;
            r_freq_valid  <= (VALID_WIDTH != 0);
            r_stretch_cnt <= SW'(VALID_WIDTH);
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            if (!w_cyc_full) r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
            if (w_edge) begin
              if (r_per_cnt == PER_LAST) begin
                r_period      <= w_cyc_full ? {CNT_W{1'b1}} : r_cyc_cnt + CNT_W'(1);
                r_overflow    <= w_cyc_full;
                r_timeout     <= 1'b0;
                r_state       <= S_DONE;
                r_freq_valid  <= (VALID_WIDTH != 0);
                r_stretch_cnt <= SW'(VALID_WIDTH);
              end else begin
                r_per_cnt <= r_per_cnt + PER_W'(1);
              end
            end
          end
        end
        S_DONE: begin
          // Stretch runs to completion regardless of enable.
          if (r_stretch_cnt != '0) begin
            r_stretch_cnt <= r_stretch_cnt - SW'(1);
            if (r_stretch_cnt == SW'(1)) r_freq_valid <= 1'b0;
          end else begin
            r_freq_valid <= 1'b0;
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter_mc.sv
`timescale 1ns/1ps
// Directed bench for freq_meter_mc, scaled to a 1 MHz nominal clock so that
// a 1 ms gate lasts 1000 cycles.
module tb_freq_meter_mc;

  localparam int unsigned ADC_W       = 10;
  localparam int unsigned CNT_W       = 17;
  localparam int unsigned CLK_HZ      = 1000000;
  localparam int unsigned N_PER       = 4;
  localparam int unsigned TIMEOUT_CYC = 1000;
  localparam int unsigned VALID_WIDTH = 200;

  logic             clk_10m = 1'b0;
  logic             rst_n;
  logic [ADC_W-1:0] adc_data;
  logic [ADC_W-1:0] thr_high;
  logic [ADC_W-1:0] thr_low;
  logic             enable;
  logic             mode;
  logic [1:0]       gate_sel;
  logic             clk_adc;
  logic [CNT_W-1:0] frequency;
  logic [CNT_W-1:0] period_cycles;
  logic             freq_valid;
  logic             overflow;
  logic             timeout;
  logic             busy;

  int errors = 0;
  int checks = 0;

  // Waveform generator: 0 = constant lo, 1 = square lo/hi with half period hp,
  // 2 = alternate 505/520 every cycle.
  int gen_kind = 0;
  int gen_lo   = 512;
  int gen_hi   = 512;
  int gen_hp   = 1;
  int gen_ph   = 0;

  freq_meter_mc #(
    .ADC_W(ADC_W), .CNT_W(CNT_W), .CLK_HZ(CLK_HZ), .N_PER(N_PER),
    .TIMEOUT_CYC(TIMEOUT_CYC), .VALID_WIDTH(VALID_WIDTH)
  ) dut (
    .clk_10m(clk_10m), .rst_n(rst_n), .adc_data(adc_data),
    .thr_high(thr_high), .thr_low(thr_low), .enable(enable), .mode(mode),
    .gate_sel(gate_sel), .clk_adc(clk_adc), .frequency(frequency),
    .period_cycles(period_cycles), .freq_valid(freq_valid),
    .overflow(overflow), .timeout(timeout), .busy(busy)
  );

  always #50 clk_10m = ~clk_10m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and update the ADC sample.
  task automatic tick();
    @(negedge clk_10m);
    gen_ph++;
    case (gen_kind)
      1:       adc_data = ((gen_ph % (2 * gen_hp)) < gen_hp) ? ADC_W'(gen_hi) : ADC_W'(gen_lo);
      2:       adc_data = (gen_ph % 2 == 0) ? ADC_W'(505) : ADC_W'(520);
      default: adc_data = ADC_W'(gen_lo);
    endcase
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_meas(input logic m, input logic [1:0] gs);
    mode     = m;
    gate_sel = gs;
    enable   = 1'b1;
    tick();
    check("busy_on_arm", 32'(busy), 1);
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (freq_valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic count_stretch(output int hi);
    hi = 0;
    while (freq_valid === 1'b1 && hi < 1000) begin
      hi++;
      tick();
    end
  endtask

  task automatic end_meas();
    int k;
    enable = 1'b0;
    k = 0;
    while ((freq_valid !== 1'b0 || busy !== 1'b0) && k < 2000) begin
      tick();
      k++;
    end
    check("back_to_idle", 32'({freq_valid, busy}), 0);
  endtask

  initial begin
    int n;
    int hi;
    int seen;
    rst_n    = 1'b0;
    enable   = 1'b0;
    mode     = 1'b0;
    gate_sel = 2'd3;
    thr_high = ADC_W'(522);
    thr_low  = ADC_W'(502);
    adc_data = ADC_W'(512);
    ticks(3);
    check("rst_frequency", 32'(frequency), 0);
    check("rst_period", 32'(period_cycles), 0);
    check("rst_valid", 32'(freq_valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    ticks(2);

    // Gate mode, 1 ms gate, 10-cycle square: 100 edges x 1000.
    gen_kind = 1; gen_lo = 312; gen_hi = 712; gen_hp = 5;
    ticks(20);
    start_meas(1'b0, 2'd3);
    wait_valid(2000, n);
    check("gate_latency", 32'(n), 1001);
    enable = 1'b0;
    check("gate_frequency", 32'(frequency), 100000);
    check("gate_overflow", 32'(overflow), 0);
    check("gate_timeout", 32'(timeout), 0);
    check("gate_period_kept", 32'(period_cycles), 0);
    count_stretch(hi);
    check("valid_width", 32'(hi), 200);
    ticks(3);
    check("busy_after_done", 32'(busy), 0);

    // Hysteresis: samples between the thresholds never produce an edge.
    gen_kind = 0; gen_lo = 400;
    ticks(10);
    gen_kind = 2;
    start_meas(1'b0, 2'd3);
    wait_valid(2000, n);
    check("hyst_latency", 32'(n), 1001);
    check("hyst_frequency", 32'(frequency), 0);
    end_meas();

    // Single 400 -> 600 step inside the gate: exactly one edge.
    gen_kind = 0; gen_lo = 400;
    ticks(10);
    start_meas(1'b0, 2'd3);
    ticks(100);
    gen_lo = 600;
    wait_valid(2000, n);
    check("step_frequency", 32'(frequency), 1000);
    end_meas();

    // Period mode: 100-cycle period over 4 periods.
    gen_kind = 1; gen_lo = 312; gen_hi = 712; gen_hp = 50;
    ticks(10);
    start_meas(1'b1, 2'd3);
    wait_valid(2000, n);
    check("period_cycles", 32'(period_cycles), 400);
    check("period_timeout", 32'(timeout), 0);
    check("period_overflow", 32'(overflow), 0);
    check("period_freq_kept", 32'(frequency), 1000);
    end_meas();

    // Timeout: constant mid-band input, no edges at all.
    gen_kind = 0; gen_lo = 400;
    ticks(10);
    gen_lo = 512;
    start_meas(1'b1, 2'd3);
    wait_valid(3000, n);
    check("timeout_latency", 32'(n), 1000);
    check("timeout_flag", 32'(timeout), 1);
    check("timeout_period", 32'(period_cycles), 0);
    check("timeout_freq_kept", 32'(frequency), 1000);
    count_stretch(hi);
    check("timeout_valid_width", 32'(hi), 200);
    end_meas();

    // Abort mid-gate: idle next cycle, no result strobe.
    gen_kind = 1; gen_lo = 312; gen_hi = 712; gen_hp = 5;
    start_meas(1'b0, 2'd3);
    ticks(100);
    enable = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 0);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (freq_valid === 1'b1) seen++;
    end
    check("abort_no_valid", 32'(seen), 0);
    check("abort_freq_kept", 32'(frequency), 1000);

    // gate_sel change mid-gate must not alter the running gate.
    start_meas(1'b0, 2'd3);
    n = 0;
    while (freq_valid !== 1'b1 && n < 3000) begin
      if (n == 50) gate_sel = 2'd0;
      tick();
      n++;
    end
    check("cfg_gate_latency", 32'(n), 1001);
    check("cfg_frequency", 32'(frequency), 100000);
    end_meas();

    // Overflow: 6-cycle period gives ~166 edges x 1000 > 2^17-1.
    gen_hp = 3;
    start_meas(1'b0, 2'd3);
    wait_valid(2000, n);
    check("ovf_frequency", 32'(frequency), 131071);
    check("ovf_flag", 32'(overflow), 1);
    enable = 1'b0;
    ticks(20);
    check("ovf_valid_mid_stretch", 32'(freq_valid), 1);

    // Reset during the stretch clears everything.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_frequency", 32'(frequency), 0);
    check("rst2_period", 32'(period_cycles), 0);
    check("rst2_valid", 32'(freq_valid), 0);
    check("rst2_overflow", 32'(overflow), 0);
    check("rst2_timeout", 32'(timeout), 0);
    check("rst2_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
